// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_pkg
// Desc   : Shared widths, state encoding and saturation helpers for the
//          fully-connected output layer sequencer.
// Rev    : 1.0
// ============================================================================
package fc_pkg;

    localparam int c_n_in_def  = 3136;
    localparam int c_n_out_def = 10;
    localparam int c_in_w_def  = 30;
    localparam int c_w_w_def   = 9;
    localparam int c_out_w_def = 38;

    localparam int c_feat_aw_def = $clog2(c_n_in_def);
    localparam int c_w_aw_def    = $clog2(c_n_in_def * c_n_out_def);
    localparam int c_b_aw_def    = $clog2(c_n_out_def);
    localparam int c_acc_w_def   = c_in_w_def + c_w_w_def + $clog2(c_n_in_def);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } fc_state_e;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Largest / smallest value representable in an out_w-bit signed result.
    function automatic logic signed [63:0] sat_hi(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module : fc_mac_pipe
// Desc   : Registered signed product, non-wrapping accumulator, bias add and
//          output saturation for one neuron at a time.
// Rev    : 1.0
// ============================================================================
module fc_mac_pipe
    import fc_pkg::*;
#(
    parameter int IN_W  = c_in_w_def,
    parameter int W_W   = c_w_w_def,
    parameter int OUT_W = c_out_w_def,
    parameter int ACC_W = c_acc_w_def
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             acc_clr,
    input  logic             bias_en,
    input  logic [IN_W-1:0]  feat_rdata,
    input  logic [W_W-1:0]   w_rdata,
    input  logic [W_W-1:0]   b_rdata,
    output logic [OUT_W-1:0] res_data
);

    localparam int c_prod_w = IN_W + W_W;
    localparam int c_sum_w  = ACC_W + 1;
    localparam logic signed [c_sum_w-1:0] c_sat_hi = c_sum_w'(sat_hi(OUT_W));
    localparam logic signed [c_sum_w-1:0] c_sat_lo = c_sum_w'(sat_lo(OUT_W));

    logic                       r_rd_vld;
    logic                       r_prod_vld;
    logic [c_prod_w-1:0]        r_prod;
    logic [ACC_W-1:0]           r_acc;
    logic [OUT_W-1:0]           r_res_data;

    logic [c_prod_w-1:0]        w_feat_ext;
    logic [c_prod_w-1:0]        w_wt_ext;
    logic [c_prod_w-1:0]        w_prod;
    logic signed [c_sum_w-1:0]  w_acc_ext;
    logic signed [c_sum_w-1:0]  w_bias_ext;
    logic signed [c_sum_w-1:0]  w_sum;

    // Operands pre-extended to the product width so the low bits are the exact signed product.
    assign w_feat_ext = {{W_W{feat_rdata[IN_W-1]}}, feat_rdata};
    assign w_wt_ext   = {{IN_W{w_rdata[W_W-1]}}, w_rdata};
    assign w_prod     = w_feat_ext * w_wt_ext;

    assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
    assign w_bias_ext = {{(c_sum_w-W_W){b_rdata[W_W-1]}}, b_rdata};
    assign w_sum      = w_acc_ext + w_bias_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld   <= 1'b0;
            r_prod_vld <= 1'b0;
            r_prod     <= '0;
            r_acc      <= '0;
            r_res_data <= '0;
        end else begin
            r_rd_vld   <= issue;
            r_prod_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_prod <= w_prod;
            end
            if (acc_clr) begin
                r_acc <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + {{(ACC_W-c_prod_w){r_prod[c_prod_w-1]}}, r_prod};
            end
            if (bias_en) begin
                if (w_sum > c_sat_hi) begin
                    r_res_data <= c_sat_hi[OUT_W-1:0];
                end else if (w_sum < c_sat_lo) begin
                    r_res_data <= c_sat_lo[OUT_W-1:0];
                end else begin
                    r_res_data <= w_sum[OUT_W-1:0];
                end
            end
        end
    end

    assign res_data = r_res_data;

endmodule
`default_nettype wire

// File: rtl/fc_layer_sched.sv
`default_nettype none
// ============================================================================
// Module : fc_layer_sched
// Desc   : Time-multiplexes one MAC pipeline across all output neurons,
//          streaming features/weights/bias and emitting one result per neuron.
// Rev    : 1.0
// ============================================================================
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int N_IN  = c_n_in_def,
    parameter int N_OUT = c_n_out_def,
    parameter int IN_W  = c_in_w_def,
    parameter int W_W   = c_w_w_def,
    parameter int OUT_W = c_out_w_def
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic [clog2_min1(N_IN)-1:0]          feat_addr,
    input  logic [IN_W-1:0]                      feat_rdata,
    output logic [clog2_min1(N_IN*N_OUT)-1:0]    w_addr,
    input  logic [W_W-1:0]                       w_rdata,
    output logic [clog2_min1(N_OUT)-1:0]         b_addr,
    input  logic [W_W-1:0]                       b_rdata,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [clog2_min1(N_OUT)-1:0]         res_idx,
    output logic [OUT_W-1:0]                     res_data
);

    localparam int c_faw   = clog2_min1(N_IN);
    localparam int c_waw   = clog2_min1(N_IN * N_OUT);
    localparam int c_baw   = clog2_min1(N_OUT);
    localparam int c_acc_w = IN_W + W_W + clog2_min1(N_IN);
    localparam logic [c_faw-1:0] c_last_i = c_faw'(N_IN - 1);
    localparam logic [c_baw-1:0] c_last_n = c_baw'(N_OUT - 1);

    fc_state_e         r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_res_valid;
    logic [c_baw-1:0]  r_res_idx;
    logic [c_faw-1:0]  r_i;
    logic [c_waw-1:0]  r_w_addr;
    logic [c_baw-1:0]  r_n;
    logic              r_drain;

    logic              w_issue;
    logic              w_acc_clr;
    logic              w_bias_en;

    assign w_issue   = (r_state == ST_RUN);
    assign w_bias_en = (r_state == ST_BIAS);
    assign w_acc_clr = ((r_state == ST_IDLE) && start) || ((r_state == ST_OUT) && res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_i         <= '0;
            r_w_addr    <= '0;
            r_n         <= '0;
            r_drain     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_i      <= '0;
                        r_w_addr <= '0;
                        r_n      <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_i == c_last_i) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_i      <= r_i + c_faw'(1);
                        r_w_addr <= r_w_addr + c_waw'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain) begin
                        r_state <= ST_BIAS;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                ST_BIAS: begin
                    r_state     <= ST_OUT;
                    r_res_valid <= 1'b1;
                    r_res_idx   <= r_n;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_n == c_last_n) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // Weight rows are contiguous, so the next row starts one past the last address.
                            r_state  <= ST_RUN;
                            r_n      <= r_n + c_baw'(1);
                            r_i      <= '0;
                            r_w_addr <= r_w_addr + c_waw'(1);
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    fc_mac_pipe #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .OUT_W (OUT_W),
        .ACC_W (c_acc_w)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (w_issue),
        .acc_clr    (w_acc_clr),
        .bias_en    (w_bias_en),
        .feat_rdata (feat_rdata),
        .w_rdata    (w_rdata),
        .b_rdata    (b_rdata),
        .res_data   (res_data)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign feat_addr = r_i;
    assign w_addr    = r_w_addr;
    assign b_addr    = r_n;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_layer_sched
// Desc   : Self-checking bench: small-config vector table plus a full-size
//          saturation / address pass against a plain-arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_fc_layer_sched;

    localparam int  c_nv    = 8;
    localparam longint c_max = (longint'(1) <<< 37) - 1;
    localparam longint c_min = -(longint'(1) <<< 37);

    typedef struct {
        logic [3:0][29:0] feat;
        logic [7:0][8:0]  w;
        logic [1:0][8:0]  b;
        int               stall;
        bit               spam_start;
        logic [1:0][37:0] exp_res;
        int               exp_done;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Small configuration: N_IN=4, N_OUT=2
    logic        s_start, s_busy, s_done, s_res_valid, s_res_ready;
    logic [1:0]  s_feat_addr;
    logic [2:0]  s_w_addr;
    logic [0:0]  s_b_addr, s_res_idx;
    logic [29:0] s_feat_rdata;
    logic [8:0]  s_w_rdata, s_b_rdata;
    logic [37:0] s_res_data;
    logic [29:0] s_feat_mem [4];
    logic [8:0]  s_w_mem [8];
    logic [8:0]  s_b_mem [2];

    // Default configuration
    logic        d_start, d_busy, d_done, d_res_valid, d_res_ready;
    logic [11:0] d_feat_addr;
    logic [14:0] d_w_addr;
    logic [3:0]  d_b_addr, d_res_idx;
    logic [29:0] d_feat_rdata;
    logic [8:0]  d_w_rdata, d_b_rdata;
    logic [37:0] d_res_data;

    vec_t vecs [c_nv];

    fc_layer_sched #(.N_IN(4), .N_OUT(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .feat_addr(s_feat_addr), .feat_rdata(s_feat_rdata),
        .w_addr(s_w_addr), .w_rdata(s_w_rdata),
        .b_addr(s_b_addr), .b_rdata(s_b_rdata),
        .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_idx(s_res_idx), .res_data(s_res_data)
    );

    fc_layer_sched u_big (
        .clk(clk), .rst_n(rst_n), .start(d_start), .busy(d_busy), .done(d_done),
        .feat_addr(d_feat_addr), .feat_rdata(d_feat_rdata),
        .w_addr(d_w_addr), .w_rdata(d_w_rdata),
        .b_addr(d_b_addr), .b_rdata(d_b_rdata),
        .res_valid(d_res_valid), .res_ready(d_res_ready),
        .res_idx(d_res_idx), .res_data(d_res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        s_feat_rdata <= s_feat_mem[s_feat_addr];
        s_w_rdata    <= s_w_mem[s_w_addr];
        s_b_rdata    <= s_b_mem[s_b_addr];
        d_feat_rdata <= 30'h1FFF_FFFF;
        d_w_rdata    <= (((int'(d_w_addr) / 3136) % 2) == 1) ? 9'h100 : 9'h0FF;
        d_b_rdata    <= 9'h000;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model(input vec_t v, input int n);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(v.feat[i])) * longint'($signed(v.w[n*4+i]));
        end
        s += longint'($signed(v.b[n]));
        if (s > c_max) s = c_max;
        if (s < c_min) s = c_min;
        return s;
    endfunction

    function automatic vec_t mk_directed(input int stall, input bit spam);
        vec_t v;
        v.feat = {30'd4, 30'd3, 30'd2, 30'd1};
        v.w    = {9'd4, 9'h1FD, 9'd2, 9'h1FF, 9'd1, 9'd1, 9'd1, 9'd1};
        v.b    = {9'h1FE, 9'd5};
        v.stall = stall;
        v.spam_start = spam;
        v.exp_res = {38'd8, 38'd15};
        v.exp_done = 17 + 2 * stall;
        return v;
    endfunction

    task automatic run_small(input vec_t v, input string tag);
        int c, k, waited, done_seen;
        bit prev_valid;
        for (int i = 0; i < 4; i++) s_feat_mem[i] = v.feat[i];
        for (int i = 0; i < 8; i++) s_w_mem[i] = v.w[i];
        for (int i = 0; i < 2; i++) s_b_mem[i] = v.b[i];
        s_res_ready = 1'b1;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        c = 1; k = 0; waited = 0; done_seen = 0; prev_valid = 1'b0;
        while (!done_seen && c < 200) begin
            chk({tag, "_busy"}, longint'(s_busy), longint'(c < v.exp_done));
            if (s_res_valid) begin
                if (k >= 2) begin
                    chk({tag, "_extra_result"}, k, 1);
                end else begin
                    if (!prev_valid)
                        chk({tag, "_valid_cycle"}, c, (k + 1) * 8 + k * v.stall);
                    chk({tag, "_res_idx"}, longint'(s_res_idx), k);
                    chk({tag, "_res_data"}, longint'($signed(s_res_data)),
                        longint'($signed(v.exp_res[k])));
                end
                s_res_ready = (waited >= v.stall);
                if (s_res_ready) begin
                    k++; waited = 0; prev_valid = 1'b0;
                end else begin
                    waited++; prev_valid = 1'b1;
                end
            end else begin
                s_res_ready = 1'b1;
            end
            if (s_done) begin
                chk({tag, "_done_cycle"}, c, v.exp_done);
                chk({tag, "_result_count"}, k, 2);
                done_seen = 1;
            end
            s_start = v.spam_start && (c % 3 == 0) && !done_seen;
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, done_seen, 1);
        s_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk({tag, "_post_quiet"}, longint'({s_done, s_res_valid, s_busy}), 0);
            @(negedge clk);
        end
    endtask

    task automatic run_big();
        int c, k, done_seen, addr_bad;
        d_res_ready = 1'b1;
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        c = 1; k = 0; done_seen = 0; addr_bad = 0;
        while (!done_seen && c < 32000) begin
            if (c >= 9421 && c <= 12556) begin
                if (int'(d_w_addr) != 9408 + (c - 9421) || int'(d_feat_addr) != c - 9421
                    || int'(d_b_addr) != 3)
                    addr_bad++;
                if (c == 9421)  chk("n3_w_addr_first", longint'(d_w_addr), 9408);
                if (c == 12556) chk("n3_w_addr_last", longint'(d_w_addr), 12543);
            end
            if (d_res_valid) begin
                chk("big_valid_cycle", c, (k + 1) * 3140);
                chk("big_res_idx", longint'(d_res_idx), k);
                chk("big_res_data", longint'($signed(d_res_data)), (k % 2 == 1) ? c_min : c_max);
                k++;
            end
            if (d_done) begin
                chk("big_done_cycle", c, 31401);
                chk("big_result_count", k, 10);
                done_seen = 1;
            end
            @(negedge clk);
            c++;
        end
        chk("big_done_seen", done_seen, 1);
        chk("n3_addr_mismatches", addr_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        s_start = 1'b0; s_res_ready = 1'b1;
        d_start = 1'b0; d_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) s_feat_mem[i] = '0;
        for (int i = 0; i < 8; i++) s_w_mem[i] = '0;
        for (int i = 0; i < 2; i++) s_b_mem[i] = '0;

        vecs[0] = mk_directed(0, 1'b0);
        vecs[1] = mk_directed(5, 1'b0);
        vecs[2] = mk_directed(0, 1'b1);
        for (int n = 3; n < c_nv; n++) begin
            for (int i = 0; i < 4; i++) vecs[n].feat[i] = 30'($urandom);
            for (int i = 0; i < 8; i++) vecs[n].w[i] = 9'($urandom);
            for (int i = 0; i < 2; i++) vecs[n].b[i] = 9'($urandom);
            vecs[n].stall = $urandom_range(0, 3);
            vecs[n].spam_start = 1'b0;
            for (int j = 0; j < 2; j++) vecs[n].exp_res[j] = 38'(model(vecs[n], j));
            vecs[n].exp_done = 17 + 2 * vecs[n].stall;
        end

        repeat (3) @(negedge clk);
        chk("rst_small_outs", longint'({s_busy, s_done, s_res_valid, s_res_idx}), 0);
        chk("rst_small_data", longint'(s_res_data), 0);
        chk("rst_small_addr", longint'({s_feat_addr, s_w_addr, s_b_addr}), 0);
        chk("rst_big_outs", longint'({d_busy, d_done, d_res_valid, d_res_idx}), 0);
        chk("rst_big_addr", longint'({d_feat_addr, d_w_addr, d_b_addr}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < c_nv; n++) begin
            run_small(vecs[n], $sformatf("vec%0d", n));
        end

        // Abort mid-pass with reset, then a clean pass must start from neuron 0.
        for (int i = 0; i < 4; i++) s_feat_mem[i] = vecs[0].feat[i];
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", longint'({s_busy, s_done, s_res_valid, s_res_idx}), 0);
        chk("abort_data", longint'(s_res_data), 0);
        chk("abort_addr", longint'({s_feat_addr, s_w_addr, s_b_addr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_small(vecs[0], "after_abort");

        run_big();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
